alu_cmd_sequencer: RTL and testbench

//  Upstream command stage for the registered 32-bit ALU (opcodes 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR).

---
 rtl/alu_cmd_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - FIFO-buffered tagged command sequencer in front of a registered 32-bit ALU
// Optional feature macro: ALU_SEQ_STATS_EN (adds stat_clr / stat_issued / stat_errors)
module alu_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_a,
   input  logic [31:0]              in_b,
   input  logic [2:0]               in_op,
   input  logic [TAG_W-1:0]         in_tag,
   output logic [31:0]              alu_a,
   output logic [31:0]              alu_b,
   output logic [2:0]               alu_opcode,
   input  logic [31:0]              alu_result,
   input  logic                     alu_error,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_result,
   output logic                     out_error,
   output logic [TAG_W-1:0]         out_tag,
`ifdef ALU_SEQ_STATS_EN
   input  logic                     stat_clr,
   output logic [15:0]              stat_issued,
   output logic [15:0]              stat_errors,
`endif
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_OUT
   } state_e;

   typedef struct packed {
      logic [31:0]      a;
      logic [31:0]      b;
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   cmd_t             fifo_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   state_e           state_q;
   logic [31:0]      alu_a_q;
   logic [31:0]      alu_b_q;
   logic [2:0]       alu_op_q;
   logic [TAG_W-1:0] tag_q;
   logic             out_valid_q;
   logic [31:0]      out_result_q;
   logic             out_error_q;
   logic [TAG_W-1:0] out_tag_q;

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             head_legal;
   cmd_t             head;

   assign full       = (count_q == CW'(DEPTH));
   assign empty      = (count_q == '0);
   assign push       = in_valid && !full;
   // A pop frees a slot only after the edge, so a full FIFO never passes a push through.
   assign pop        = !empty && ((state_q == S_IDLE) || ((state_q == S_OUT) && out_ready));
   assign head       = fifo_q[rd_ptr_q];
   assign head_legal = (head.op <= 3'd4);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= '{a: in_a, b: in_b, op: in_op, tag: in_tag};
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= 3'b010;
         tag_q        <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_error_q  <= 1'b0;
         out_tag_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_OUT: begin
               if (pop) begin
                  if (head_legal) begin
                     alu_a_q     <= head.a;
                     alu_b_q     <= head.b;
                     alu_op_q    <= head.op;
                     tag_q       <= head.tag;
                     out_valid_q <= 1'b0;
                     state_q     <= S_ISSUE;
                  end else begin
                     // Illegal opcodes complete locally; the ALU keeps its last operands.
                     out_result_q <= '0;
                     out_error_q  <= 1'b1;
                     out_tag_q    <= head.tag;
                     out_valid_q  <= 1'b1;
                     state_q      <= S_OUT;
                  end
               end else if ((state_q == S_OUT) && out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            S_ISSUE: begin
               state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               out_result_q <= alu_result;
               out_error_q  <= alu_error;
               out_tag_q    <= tag_q;
               out_valid_q  <= 1'b1;
               state_q      <= S_OUT;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef ALU_SEQ_STATS_EN
   logic [15:0] stat_issued_q;
   logic [15:0] stat_errors_q;
   logic        issue_evt;
   logic        error_evt;

   assign issue_evt = pop && head_legal;
   assign error_evt = (state_q == S_OUT) && out_ready && out_error_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_issued_q <= '0;
         stat_errors_q <= '0;
      end else if (stat_clr) begin
         stat_issued_q <= '0;
         stat_errors_q <= '0;
      end else begin
         if (issue_evt && (stat_issued_q != 16'hFFFF)) stat_issued_q <= stat_issued_q + 16'd1;
         if (error_evt && (stat_errors_q != 16'hFFFF)) stat_errors_q <= stat_errors_q + 16'd1;
      end
   end

   assign stat_issued = stat_issued_q;
   assign stat_errors = stat_errors_q;
`endif

   assign in_ready   = !full;
   assign fifo_count = count_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_op_q;
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_error  = out_error_q;
   assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer
// Stats checks compile in only when ALU_SEQ_STATS_EN is defined.
module tb_alu_cmd_sequencer;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic [2:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic [31:0]      alu_a;
   logic [31:0]      alu_b;
   logic [2:0]       alu_opcode;
   logic [31:0]      alu_result = '0;
   logic             alu_error = 1'b0;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic             out_error;
   logic [TAG_W-1:0] out_tag;
   logic [$clog2(DEPTH):0] fifo_count;
`ifdef ALU_SEQ_STATS_EN
   logic             stat_clr;
   logic [15:0]      stat_issued;
   logic [15:0]      stat_errors;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic bad_op = 1'b0;

   alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .in_tag     (in_tag),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_opcode (alu_opcode),
      .alu_result (alu_result),
      .alu_error  (alu_error),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_error  (out_error),
      .out_tag    (out_tag),
`ifdef ALU_SEQ_STATS_EN
      .stat_clr   (stat_clr),
      .stat_issued(stat_issued),
      .stat_errors(stat_errors),
`endif
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Registered ALU stand-in: samples operands every edge, flags signed overflow on ADD/SUB.
   always @(posedge clk) begin
      logic [31:0] s;
      case (alu_opcode)
         3'd0: begin
            s = alu_a + alu_b;
            alu_result <= s;
            alu_error  <= (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]);
         end
         3'd1: begin
            s = alu_a - alu_b;
            alu_result <= s;
            alu_error  <= (alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]);
         end
         3'd2: begin alu_result <= alu_a & alu_b; alu_error <= 1'b0; end
         3'd3: begin alu_result <= alu_a | alu_b; alu_error <= 1'b0; end
         3'd4: begin alu_result <= alu_a ^ alu_b; alu_error <= 1'b0; end
         default: begin alu_result <= '0; alu_error <= 1'b1; end
      endcase
      if (alu_opcode > 3'd4) bad_op <= 1'b1;
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [3:0]  tag;
      logic [31:0] r;
      logic        e;
   } vec_t;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [3:0] tag);
      int n = 0;
      in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) check("push_timeout", in_ready, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string nm);
      int n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      check({nm, "_valid"}, out_valid, 1);
   endtask

   task automatic check_out(input string nm, input logic [31:0] r, input logic e,
                            input logic [3:0] t);
      check({nm, "_res"}, out_result, r);
      check({nm, "_err"}, out_error, e);
      check({nm, "_tag"}, out_tag, t);
   endtask

   task automatic collect(input string nm, input vec_t v, output int at);
      wait_valid(nm);
      at = cyc;
      check_out(nm, v.r, v.e, v.tag);
      tick();
   endtask

   vec_t v2[5] = '{
      '{32'd10,        32'd4,       3'd1, 4'd1, 32'd6,        1'b0},
      '{32'hFF00,      32'h0FF0,    3'd2, 4'd2, 32'h0F00,     1'b0},
      '{32'd1,         32'd2,       3'd3, 4'd3, 32'd3,        1'b0},
      '{32'd7,         32'd7,       3'd4, 4'd4, 32'd0,        1'b0},
      '{32'h7FFFFFFF,  32'd1,       3'd0, 4'd5, 32'h80000000, 1'b1}
   };
   vec_t v4[4] = '{
      '{32'd1,   32'd1, 3'd0, 4'd1, 32'd2,    1'b0},
      '{32'd100, 32'd1, 3'd1, 4'd2, 32'd99,   1'b0},
      '{32'hF,   32'h3, 3'd2, 4'd3, 32'd3,    1'b0},
      '{32'h10,  32'h1, 3'd3, 4'd4, 32'h11,   1'b0}
   };
   vec_t v3[2] = '{
      '{32'hF0, 32'h3C, 3'd4, 4'd2, 32'hCC, 1'b0},
      '{32'h0,  32'h0,  3'd6, 4'd3, 32'h0,  1'b1}
   };

   initial begin
      int at;
      int t4[4];
      logic [31:0] hold_r;
      logic [3:0]  hold_t;
      logic        seen;

      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
      out_ready = 1'b0;
`ifdef ALU_SEQ_STATS_EN
      stat_clr = 1'b0;
`endif
      tick(); tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_alu_op", alu_opcode, 3'b010);
      check("rst_alu_a", alu_a, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_count", fifo_count, 0);
      rst_n = 1'b1;
      tick();

      // 1: single ADD, latency 3
      out_ready = 1'b1;
      push(32'd5, 32'd3, 3'd0, 4'd1);
      check("t1_count", fifo_count, 1);
      tick();
      check("t1_issue_op", alu_opcode, 3'd0);
      check("t1_issue_a", alu_a, 5);
      check("t1_v1", out_valid, 0);
      tick();
      check("t1_v2", out_valid, 0);
      tick();
      check("t1_v3", out_valid, 1);
      check_out("t1", 32'd8, 1'b0, 4'd1);
      tick();
      check("t1_done", out_valid, 0);

      // 2: fill while consumer stalls, then drain in order
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(v2[i].a, v2[i].b, v2[i].op, v2[i].tag);
      check("t2_full_count", fifo_count, DEPTH);
      check("t2_full_ready", in_ready, 0);
      wait_valid("t2_c0");
      hold_r = out_result; hold_t = out_tag;
      in_a = 32'hDEAD; in_b = 32'h1; in_op = 3'd0; in_tag = 4'hF; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_hold_res", out_result, hold_r);
         check("t2_hold_tag", out_tag, hold_t);
         check("t2_hold_count", fifo_count, DEPTH);
      end
      check_out("t2_c0", v2[0].r, v2[0].e, v2[0].tag);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t2_full_pop_count", fifo_count, DEPTH - 1);
      for (int i = 1; i < 5; i++) collect($sformatf("t2_c%0d", i), v2[i], at);
      out_ready = 1'b0;

      // 3: legal XOR followed by illegal opcode
      out_ready = 1'b1;
      push(v3[0].a, v3[0].b, v3[0].op, v3[0].tag);
      push(v3[1].a, v3[1].b, v3[1].op, v3[1].tag);
      collect("t3_xor", v3[0], at);
      collect("t3_ill", v3[1], at);
      tick();

      // illegal opcode latency: valid after edge 1
      push(32'd9, 32'd9, 3'd7, 4'd5);
      check("t3b_v0", out_valid, 0);
      tick();
      check("t3b_v1", out_valid, 1);
      check_out("t3b", 32'd0, 1'b1, 4'd5);
      tick();
      check("t3b_done", out_valid, 0);

      // 4: streaming throughput
      fork
         begin
            for (int i = 0; i < 4; i++) push(v4[i].a, v4[i].b, v4[i].op, v4[i].tag);
         end
         begin
            for (int k = 0; k < 4; k++) begin
               collect($sformatf("t4_s%0d", k), v4[k], at);
               t4[k] = at;
            end
         end
      join
      for (int k = 1; k < 4; k++) check("t4_spacing", t4[k] - t4[k-1], 3);

      // simultaneous push and pop on a non-full FIFO
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(v4[i].a, v4[i].b, v4[i].op, v4[i].tag);
      wait_valid("t4p_d0");
      check("t4p_count_before", fifo_count, 2);
      check_out("t4p_d0", v4[0].r, v4[0].e, v4[0].tag);
      in_a = v4[3].a; in_b = v4[3].b; in_op = v4[3].op; in_tag = v4[3].tag; in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t4p_count_same", fifo_count, 2);
      for (int i = 1; i < 4; i++) collect($sformatf("t4p_d%0d", i), v4[i], at);

      // 5: reset while in CAPTURE
      out_ready = 1'b0;
      push(32'd2, 32'd2, 3'd0, 4'd6);
      push(32'd3, 32'd3, 3'd0, 4'd7);
      tick();
      rst_n = 1'b0;
      #1;
      check("t5_valid", out_valid, 0);
      check("t5_count", fifo_count, 0);
      check("t5_ready", in_ready, 1);
      check("t5_alu_op", alu_opcode, 3'b010);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check("t5_no_output", seen, 0);

`ifdef ALU_SEQ_STATS_EN
      // 6: statistics
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      check("t6_clr_issued", stat_issued, 0);
      fork
         begin
            for (int i = 0; i < 3; i++) push(v4[i].a, v4[i].b, v4[i].op, v4[i].tag);
            push(32'd0, 32'd0, 3'd5, 4'd9);
         end
         begin
            for (int k = 0; k < 3; k++) collect($sformatf("t6_s%0d", k), v4[k], at);
            collect("t6_ill", '{32'd0, 32'd0, 3'd5, 4'd9, 32'd0, 1'b1}, at);
         end
      join
      check("t6_issued", stat_issued, 3);
      check("t6_errors", stat_errors, 1);
      push(32'd4, 32'd4, 3'd0, 4'd8);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      collect("t6_clr_evt", '{32'd4, 32'd4, 3'd0, 4'd8, 32'd8, 1'b0}, at);
      check("t6_clr_issued_same_cycle", stat_issued, 0);
      check("t6_clr_errors", stat_errors, 0);
`endif

      check("never_illegal_alu_op", bad_op, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
